cmsdk_mcu_stclk_sched: RTL and testbench

Programmable SysTick reference-clock controller for the Cortex-M0 MCU. Generates the STCLKEN toggle from FCLK with a software-configurable divide ratio, and sequences start, stop and ratio changes so that STCLKEN never produces a runt phase. A simple synchronous register port configures it, and it drives the STCALIB value seen by the processor.

---
 rtl/cmsdk_mcu_stclk_sched.sv | 174 +++++++++++++++++
 tb/tb_cmsdk_mcu_stclk_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmsdk_mcu_stclk_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmsdk_mcu_stclk_sched: SysTick reference-clock divider that keeps every   |
// | STCLKEN phase full-length across start, stop and ratio changes. Rev 1.0   |
// +--------------------------------------------------------------------------+
module cmsdk_mcu_stclk_sched #(
  parameter logic [17:0] DEFAULT_RATIO = 18'd1000,
  parameter logic [23:0] DEFAULT_CAL   = 24'd0,
  parameter logic [17:0] MIN_RATIO     = 18'd2
) (
  input  logic        FCLK,
  input  logic        SYSRESET,
  input  logic        CFG_WE,
  input  logic [1:0]  CFG_ADDR,
  input  logic [31:0] CFG_WDATA,
  output logic [31:0] CFG_RDATA,
  output logic        STCLKEN,
  output logic [25:0] STCALIB,
  output logic        RUNNING
);

  // STATUS[3:2] exposes these codes directly.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        stclken_q, stclken_d;
  logic [17:0] cnt_q, cnt_d;
  logic [17:0] active_q, active_d;
  logic [17:0] pending_q, pending_d;
  logic        upd_q, upd_d;
  logic        en_q, en_d;
  logic        skew_q, skew_d;
  logic [23:0] cal_q, cal_d;

  logic        wr_ctrl, wr_ratio, wr_cal, en_wr1, dis_wr;
  logic [17:0] wr_ratio_val, reload_cur, reload_pend;
  logic        go_idle, stop_count;
  logic        unused_wdata;

  assign wr_ctrl      = CFG_WE & (CFG_ADDR == 2'd0);
  assign wr_ratio     = CFG_WE & (CFG_ADDR == 2'd1);
  assign wr_cal       = CFG_WE & (CFG_ADDR == 2'd2);
  assign en_wr1       = wr_ctrl & CFG_WDATA[0];
  assign dis_wr       = wr_ctrl & ~CFG_WDATA[0];
  assign wr_ratio_val = (CFG_WDATA[17:0] < MIN_RATIO) ? MIN_RATIO : CFG_WDATA[17:0];
  assign reload_cur   = (active_q >> 1) - 18'd1;
  assign reload_pend  = (pending_q >> 1) - 18'd1;
  assign unused_wdata = ^CFG_WDATA[31:24];

  always_comb begin
    state_d    = state_q;
    stclken_d  = stclken_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    pending_d  = pending_q;
    upd_d      = upd_q;
    en_d       = en_q;
    skew_d     = skew_q;
    cal_d      = cal_q;
    go_idle    = 1'b0;
    stop_count = 1'b0;

    if (wr_ctrl) begin
      en_d   = CFG_WDATA[0];
      skew_d = CFG_WDATA[1];
    end
    if (wr_cal) cal_d = CFG_WDATA[23:0];

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        stclken_d = 1'b0;
        if (wr_ratio) begin
          active_d  = wr_ratio_val;
          pending_d = wr_ratio_val;
        end
        if (en_wr1) begin
          state_d = ST_RUN;
          cnt_d   = reload_cur;
        end
      end
      ST_RUN, ST_STOPPING: begin
        // Re-enabling while stopping simply resumes normal counting.
        stop_count = (state_q == ST_RUN) ? dis_wr : ~en_wr1;
        if ((state_q == ST_RUN) && dis_wr && !stclken_q) begin
          go_idle = 1'b1;
        end else if (stop_count) begin
          if (cnt_q == '0) begin
            go_idle = 1'b1;
          end else begin
            cnt_d   = cnt_q - 18'd1;
            state_d = ST_STOPPING;
          end
        end else begin
          state_d = ST_RUN;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 18'd1;
          end else begin
            stclken_d = ~stclken_q;
            // Ratio updates only land on the falling toggle.
            if (stclken_q && upd_q) begin
              active_d = pending_q;
              upd_d    = 1'b0;
              cnt_d    = reload_pend;
            end else begin
              cnt_d = reload_cur;
            end
          end
        end

        if (go_idle) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          stclken_d = 1'b0;
          upd_d     = 1'b0;
          if (upd_q) active_d = pending_q;
        end

        if (wr_ratio) begin
          pending_d = wr_ratio_val;
          if (go_idle) active_d = wr_ratio_val;
          else         upd_d    = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        stclken_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge FCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      state_q   <= ST_IDLE;
      stclken_q <= 1'b0;
      cnt_q     <= '0;
      active_q  <= DEFAULT_RATIO;
      pending_q <= DEFAULT_RATIO;
      upd_q     <= 1'b0;
      en_q      <= 1'b0;
      skew_q    <= 1'b1;
      cal_q     <= DEFAULT_CAL;
    end else begin
      state_q   <= state_d;
      stclken_q <= stclken_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
      en_q      <= en_d;
      skew_q    <= skew_d;
      cal_q     <= cal_d;
    end
  end

  assign STCLKEN = stclken_q;
  assign RUNNING = (state_q == ST_RUN) | (state_q == ST_STOPPING);
  assign STCALIB = {~RUNNING, skew_q, cal_q};

  always_comb begin
    CFG_RDATA = '0;
    case (CFG_ADDR)
      2'd0:    CFG_RDATA = {30'd0, skew_q, en_q};
      2'd1:    CFG_RDATA = {14'd0, pending_q};
      2'd2:    CFG_RDATA = {8'd0, cal_q};
      default: CFG_RDATA = {28'd0, state_q, upd_q, RUNNING};
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cmsdk_mcu_stclk_sched.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for cmsdk_mcu_stclk_sched: directed vector table, corner-case
// sequences and a randomized run against a phase-level reference model.
module tb_cmsdk_mcu_stclk_sched;

  logic        FCLK = 1'b0;
  logic        SYSRESET = 1'b1;
  logic        CFG_WE = 1'b0;
  logic [1:0]  CFG_ADDR = 2'd0;
  logic [31:0] CFG_WDATA = 32'd0;
  logic [31:0] CFG_RDATA;
  logic        STCLKEN;
  logic [25:0] STCALIB;
  logic        RUNNING;

  cmsdk_mcu_stclk_sched dut (
    .FCLK      (FCLK),
    .SYSRESET  (SYSRESET),
    .CFG_WE    (CFG_WE),
    .CFG_ADDR  (CFG_ADDR),
    .CFG_WDATA (CFG_WDATA),
    .CFG_RDATA (CFG_RDATA),
    .STCLKEN   (STCLKEN),
    .STCALIB   (STCALIB),
    .RUNNING   (RUNNING)
  );

  always #5 FCLK = ~FCLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge FCLK);
    #1;
  endtask

  task automatic do_reset();
    CFG_WE = 1'b0; CFG_ADDR = 2'd0; CFG_WDATA = 32'd0;
    SYSRESET = 1'b1;
    repeat (2) @(posedge FCLK);
    #1 SYSRESET = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    CFG_WE = 1'b1; CFG_ADDR = a; CFG_WDATA = d;
    tick();
    CFG_WE = 1'b0;
  endtask

  // ---------------- phase-level reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_STOP} mst_t;
  mst_t      m_st;
  bit        m_out, m_upd, m_en, m_skew;
  int        m_active, m_pending, m_len, m_age;
  bit [23:0] m_cal;

  function automatic int clampr(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic m_reset();
    m_st = M_IDLE; m_out = 0; m_upd = 0; m_en = 0; m_skew = 1;
    m_active = 1000; m_pending = 1000; m_len = 1; m_age = 0; m_cal = 24'd0;
  endtask

  task automatic m_go_idle();
    if (m_upd) m_active = m_pending;
    m_upd = 0; m_out = 0; m_st = M_IDLE;
  endtask

  // m_len = edges in the current phase, m_age = edges already spent in it.
  task automatic m_edge(input bit we, input bit [1:0] a, input bit [31:0] d);
    bit   ctl, en1, dis, rw;
    int   v;
    mst_t st0;
    ctl = we && (a == 2'd0);
    en1 = ctl && d[0];
    dis = ctl && !d[0];
    rw  = we && (a == 2'd1);
    v   = clampr(int'(d[17:0]));
    st0 = m_st;
    if (ctl) begin m_en = d[0]; m_skew = d[1]; end
    if (we && a == 2'd2) m_cal = d[23:0];
    if (st0 == M_IDLE) begin
      if (rw) begin m_active = v; m_pending = v; end
      if (en1) begin m_st = M_RUN; m_len = m_active / 2; m_age = 0; end
    end else begin
      if (st0 == M_RUN && dis && !m_out) begin
        m_go_idle();
      end else if ((st0 == M_RUN && dis) || (st0 == M_STOP && !en1)) begin
        if (m_age == m_len - 1) m_go_idle();
        else begin m_age++; m_st = M_STOP; end
      end else begin
        m_st = M_RUN;
        if (m_age == m_len - 1) begin
          if (m_out && m_upd) begin m_active = m_pending; m_upd = 0; end
          m_out = !m_out; m_len = m_active / 2; m_age = 0;
        end else begin
          m_age++;
        end
      end
      if (rw) begin
        if (m_st == M_IDLE) begin m_active = v; m_pending = v; end
        else begin m_pending = v; m_upd = 1; end
      end
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [1:0] code;
    logic       run;
    code = (m_st == M_RUN) ? 2'd1 : (m_st == M_STOP) ? 2'd2 : 2'd0;
    run  = (m_st != M_IDLE);
    case (a)
      2'd0:    return {30'd0, m_skew, m_en};
      2'd1:    return 32'(m_pending);
      2'd2:    return {8'd0, m_cal};
      default: return {28'd0, code, m_upd, run};
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit        we;
    bit [1:0]  addr;
    bit [31:0] wdata;
    bit        exp_clk;
    bit        exp_run;
    bit [25:0] exp_cal;
    bit [31:0] exp_rd;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input bit we, input bit [1:0] a, input bit [31:0] d,
                              input bit c, input bit r, input bit [25:0] cal,
                              input bit [31:0] rd);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.exp_clk = c; v.exp_run = r;
    v.exp_cal = cal; v.exp_rd = rd;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k_found;

    // Ratio 1 clamps to 2 (toggle every cycle); ratio 7 gives 3-cycle phases.
    tbl[0]  = mk(0, 2'd1, 32'd0,          0, 0, 26'h3000000, 32'd1000);
    tbl[1]  = mk(1, 2'd1, 32'd1,          0, 0, 26'h3000000, 32'd2);
    tbl[2]  = mk(0, 2'd3, 32'd0,          0, 0, 26'h3000000, 32'd0);
    tbl[3]  = mk(1, 2'd0, 32'd3,          0, 1, 26'h1000000, 32'd3);
    tbl[4]  = mk(0, 2'd3, 32'd0,          1, 1, 26'h1000000, 32'd5);
    tbl[5]  = mk(0, 2'd3, 32'd0,          0, 1, 26'h1000000, 32'd5);
    tbl[6]  = mk(1, 2'd1, 32'd7,          1, 1, 26'h1000000, 32'd7);
    tbl[7]  = mk(0, 2'd3, 32'd0,          0, 1, 26'h1000000, 32'd5);
    tbl[8]  = mk(0, 2'd3, 32'd0,          0, 1, 26'h1000000, 32'd5);
    tbl[9]  = mk(0, 2'd3, 32'd0,          0, 1, 26'h1000000, 32'd5);
    tbl[10] = mk(0, 2'd3, 32'd0,          1, 1, 26'h1000000, 32'd5);
    tbl[11] = mk(0, 2'd3, 32'd0,          1, 1, 26'h1000000, 32'd5);
    tbl[12] = mk(0, 2'd3, 32'd0,          1, 1, 26'h1000000, 32'd5);
    tbl[13] = mk(0, 2'd3, 32'd0,          0, 1, 26'h1000000, 32'd5);
    tbl[14] = mk(1, 2'd0, 32'd2,          0, 0, 26'h3000000, 32'd2);
    tbl[15] = mk(1, 2'd2, 32'h00123456,   0, 0, 26'h3123456, 32'h123456);
    tbl[16] = mk(0, 2'd3, 32'd0,          0, 0, 26'h3123456, 32'd0);
    tbl[17] = mk(1, 2'd3, 32'hFFFFFFFF,   0, 0, 26'h3123456, 32'd0);
    tbl[18] = mk(1, 2'd1, 32'hFFFC0005,   0, 0, 26'h3123456, 32'd5);

    do_reset();
    CFG_ADDR = 2'd1;
    #1;
    check("reset_stclken", {31'd0, STCLKEN}, 32'd0);
    check("reset_stcalib", {6'd0, STCALIB}, 32'h3000000);
    check("reset_ratio",   CFG_RDATA, 32'd1000);
    check("reset_running", {31'd0, RUNNING}, 32'd0);

    for (int i = 0; i < 19; i++) begin
      CFG_WE = tbl[i].we; CFG_ADDR = tbl[i].addr; CFG_WDATA = tbl[i].wdata;
      tick();
      CFG_WE = 1'b0;
      check($sformatf("vec%0d_stclken", i), {31'd0, STCLKEN}, {31'd0, tbl[i].exp_clk});
      check($sformatf("vec%0d_running", i), {31'd0, RUNNING}, {31'd0, tbl[i].exp_run});
      check($sformatf("vec%0d_stcalib", i), {6'd0, STCALIB}, {6'd0, tbl[i].exp_cal});
      check($sformatf("vec%0d_rdata", i),   CFG_RDATA, tbl[i].exp_rd);
    end

    // ---- ratio 10: first rise 5 edges after enable, then 5-edge phases ----
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'd3);
    k_found = -1;
    for (int k = 1; k <= 20; k++) begin tick(); if (STCLKEN) begin k_found = k; break; end end
    check("first_rise_latency", k_found, 32'd5);
    check("run_noref", {31'd0, STCALIB[25]}, 32'd0);
    k_found = -1;
    for (int k = 1; k <= 20; k++) begin tick(); if (!STCLKEN) begin k_found = k; break; end end
    check("high_phase_len", k_found, 32'd5);
    k_found = -1;
    for (int k = 1; k <= 20; k++) begin tick(); if (STCLKEN) begin k_found = k; break; end end
    check("low_phase_len", k_found, 32'd5);

    // Disable with two counts left in the high phase.
    tick(); tick();
    wr(2'd0, 32'd2);
    CFG_ADDR = 2'd3;
    #1;
    check("stopping_clk_high", {31'd0, STCLKEN}, 32'd1);
    check("stopping_status",   CFG_RDATA, 32'd9);
    tick();
    check("stopping_still_high", {31'd0, STCLKEN}, 32'd1);
    tick();
    check("stopping_fall", {31'd0, STCLKEN}, 32'd0);
    check("stopping_idle", CFG_RDATA, 32'd0);

    // Disable during the low phase: immediate IDLE.
    wr(2'd0, 32'd3);
    tick(); tick();
    check("low_run_clk",  {31'd0, STCLKEN}, 32'd0);
    check("low_run_flag", {31'd0, RUNNING}, 32'd1);
    wr(2'd0, 32'd2);
    check("low_dis_clk",   {31'd0, STCLKEN}, 32'd0);
    check("low_dis_run",   {31'd0, RUNNING}, 32'd0);
    check("low_dis_noref", {31'd0, STCALIB[25]}, 32'd1);

    // ---- asynchronous reset in the middle of a high phase ----
    wr(2'd2, 32'h00ABCDEF);
    wr(2'd0, 32'd3);
    k_found = -1;
    for (int k = 1; k <= 20; k++) begin tick(); if (STCLKEN) begin k_found = k; break; end end
    check("pre_reset_rise", k_found, 32'd5);
    #3 SYSRESET = 1'b1;
    #1;
    check("async_reset_clk", {31'd0, STCLKEN}, 32'd0);
    check("async_reset_run", {31'd0, RUNNING}, 32'd0);
    @(posedge FCLK);
    #1 SYSRESET = 1'b0;
    CFG_ADDR = 2'd1; #1;
    check("post_reset_ratio", CFG_RDATA, 32'd1000);
    CFG_ADDR = 2'd2; #1;
    check("post_reset_cal", CFG_RDATA, 32'd0);
    CFG_ADDR = 2'd0; #1;
    check("post_reset_ctrl", CFG_RDATA, 32'd2);
    wr(2'd0, 32'd3);
    k_found = -1;
    for (int k = 1; k <= 600; k++) begin tick(); if (STCLKEN) begin k_found = k; break; end end
    check("post_reset_active_ratio", k_found, 32'd500);

    // ---- randomized run against the reference model ----
    do_reset();
    m_reset();
    for (int n = 0; n < 4000; n++) begin
      logic        we;
      logic [1:0]  a;
      logic [31:0] d;
      we = ($urandom_range(0, 5) == 0);
      a  = 2'($urandom_range(0, 3));
      d  = $urandom;
      if (a == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
      if (a == 2'd1) d = 32'($urandom_range(0, 14));
      CFG_WE = we; CFG_ADDR = a; CFG_WDATA = d;
      tick();
      m_edge(we, a, d);
      check("rand_stclken", {31'd0, STCLKEN}, {31'd0, m_out});
      check("rand_running", {31'd0, RUNNING}, {31'd0, (m_st != M_IDLE)});
      check("rand_stcalib", {6'd0, STCALIB}, {6'd0, (m_st == M_IDLE), m_skew, m_cal});
      check("rand_rdata",   CFG_RDATA, m_read(a));
      CFG_WE = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
